// File: rtl/etapa_mem_if.sv
// rtl/etapa_mem_if.sv - EX/MEM-side request bus and MEM-stage results for etapa_mem
interface etapa_mem_if #(
    parameter int NBITS     = 32,
    parameter int ADDR_BITS = 8
);
    logic [NBITS-1:0]     i_ALU;
    logic [NBITS-1:0]     i_Registro2;
    logic                 i_MemWrite;
    logic                 i_MemRead;
    logic [1:0]           i_TamanoFiltro;
    logic                 i_LoadUnsigned;
    logic                 i_Branch;
    logic                 i_Cero;
    logic [NBITS-1:0]     i_PCBranch;
    logic [ADDR_BITS-1:0] i_DebugAddr;
    logic [NBITS-1:0]     o_ReadData;
    logic                 o_PCSrc;
    logic [NBITS-1:0]     o_PCBranch;
    logic                 o_Misaligned;
    logic [NBITS-1:0]     o_DebugData;

    modport master (
        output i_ALU, i_Registro2, i_MemWrite, i_MemRead, i_TamanoFiltro,
               i_LoadUnsigned, i_Branch, i_Cero, i_PCBranch, i_DebugAddr,
        input  o_ReadData, o_PCSrc, o_PCBranch, o_Misaligned, o_DebugData
    );

    modport slave (
        input  i_ALU, i_Registro2, i_MemWrite, i_MemRead, i_TamanoFiltro,
               i_LoadUnsigned, i_Branch, i_Cero, i_PCBranch, i_DebugAddr,
        output o_ReadData, o_PCSrc, o_PCBranch, o_Misaligned, o_DebugData
    );
endinterface

// File: rtl/etapa_mem.sv
// rtl/etapa_mem.sv - MIPS MEM stage: data memory, lane merge/extract, branch decision, debug port
module etapa_mem #(
    parameter int NBITS     = 32,
    parameter int MEM_WORDS = 256,
    parameter int ADDR_BITS = 8
) (
    input logic         i_clk,
    input logic         i_reset,
    etapa_mem_if.slave  bus
);
    logic [NBITS-1:0]     mem [MEM_WORDS];
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           byte_off;
    logic [NBITS-1:0]     cur_word;
    logic [NBITS-1:0]     wr_word;
    logic [NBITS-1:0]     shifted;
    logic [NBITS-1:0]     rd_data;
    logic                 misaligned;
    logic                 misaligned_q;
    logic [NBITS-1:0]     debug_q;
    logic                 unused_alu_hi;

    // Upper address bits are dropped so accesses wrap around the array.
    assign word_idx      = bus.i_ALU[ADDR_BITS+1:2];
    assign byte_off      = bus.i_ALU[1:0];
    assign unused_alu_hi = ^bus.i_ALU[NBITS-1:ADDR_BITS+2];
    assign cur_word      = mem[word_idx];

    always_comb begin
        misaligned = 1'b0;
        if (bus.i_MemRead || bus.i_MemWrite) begin
            case (bus.i_TamanoFiltro)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = byte_off[0];
                default: misaligned = (byte_off != 2'b00);
            endcase
        end
    end

    always_comb begin
        wr_word = cur_word;
        case (bus.i_TamanoFiltro)
            2'b00:   wr_word[{byte_off, 3'b000} +: 8]        = bus.i_Registro2[7:0];
            2'b01:   wr_word[{byte_off[1], 4'b0000} +: 16]   = bus.i_Registro2[15:0];
            default: wr_word                                 = bus.i_Registro2;
        endcase
    end

    // Loads read the array before the edge, so a same-cycle store is not visible yet.
    always_comb begin
        shifted = cur_word >> {byte_off, 3'b000};
        case (bus.i_TamanoFiltro)
            2'b00:   rd_data = bus.i_LoadUnsigned ? {{(NBITS-8){1'b0}}, shifted[7:0]}
                                                  : {{(NBITS-8){shifted[7]}}, shifted[7:0]};
            2'b01:   rd_data = bus.i_LoadUnsigned ? {{(NBITS-16){1'b0}}, shifted[15:0]}
                                                  : {{(NBITS-16){shifted[15]}}, shifted[15:0]};
            default: rd_data = cur_word;
        endcase
        if (!bus.i_MemRead || misaligned) begin
            rd_data = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
            misaligned_q <= 1'b0;
            debug_q      <= '0;
        end else begin
            if (bus.i_MemWrite && !misaligned) begin
                mem[word_idx] <= wr_word;
            end
            if (misaligned) begin
                misaligned_q <= 1'b1;
            end
            debug_q <= mem[bus.i_DebugAddr];
        end
    end

    assign bus.o_ReadData   = rd_data;
    assign bus.o_PCSrc      = bus.i_Branch & bus.i_Cero;
    assign bus.o_PCBranch   = bus.i_PCBranch;
    assign bus.o_Misaligned = misaligned_q;
    assign bus.o_DebugData  = debug_q;
endmodule

// File: tb/tb_etapa_mem.sv
// tb/tb_etapa_mem.sv - self-checking bench for etapa_mem against a byte-addressed memory model
module tb_etapa_mem;
    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    etapa_mem_if #(.NBITS(32), .ADDR_BITS(8)) bus ();

    etapa_mem #(.NBITS(32), .MEM_WORDS(256), .ADDR_BITS(8)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] bmem [1024];
    logic       mis_m;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  tf;
        logic        lu;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned acc_size(input logic [1:0] tf);
        return (tf == 2'b00) ? 1 : (tf == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_misal(input logic re, input logic we,
                                         input logic [1:0] tf, input logic [31:0] addr);
        return (re || we) && ((addr % acc_size(tf)) != 0);
    endfunction

    function automatic logic [31:0] model_word(input int unsigned widx);
        int unsigned a;
        a = (widx * 4) % 1024;
        return {bmem[a+3], bmem[a+2], bmem[a+1], bmem[a]};
    endfunction

    function automatic logic [31:0] model_read(input logic re, input logic we, input logic [1:0] tf,
                                               input logic lu, input logic [31:0] addr);
        int unsigned a;
        logic [31:0] v;
        if (!re || model_misal(re, we, tf, addr)) return 32'h0;
        a = addr % 1024;
        v = 32'h0;
        for (int i = 0; i < int'(acc_size(tf)); i++) v = v | (32'(bmem[a+i]) << (8*i));
        if (acc_size(tf) == 1 && !lu && v[7])  v = v | 32'hFFFF_FF00;
        if (acc_size(tf) == 2 && !lu && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // One clock: check combinational outputs before the edge, advance the model, check state after.
    task automatic do_cycle(output logic [31:0] rd_seen);
        logic [31:0] exp_rd, exp_dbg;
        int unsigned a;
        @(negedge i_clk);
        exp_rd  = model_read(bus.i_MemRead, bus.i_MemWrite, bus.i_TamanoFiltro,
                             bus.i_LoadUnsigned, bus.i_ALU);
        exp_dbg = i_reset ? 32'h0 : model_word(int'(bus.i_DebugAddr));
        rd_seen = bus.o_ReadData;
        check("read_data", bus.o_ReadData, exp_rd);
        check("pc_src", {31'b0, bus.o_PCSrc}, {31'b0, bus.i_Branch && bus.i_Cero});
        check("pc_branch", bus.o_PCBranch, bus.i_PCBranch);
        if (i_reset) begin
            for (int i = 0; i < 1024; i++) bmem[i] = 8'h00;
            mis_m = 1'b0;
        end else begin
            if (model_misal(bus.i_MemRead, bus.i_MemWrite, bus.i_TamanoFiltro, bus.i_ALU)) begin
                mis_m = 1'b1;
            end else if (bus.i_MemWrite) begin
                a = bus.i_ALU % 1024;
                for (int i = 0; i < int'(acc_size(bus.i_TamanoFiltro)); i++)
                    bmem[a+i] = bus.i_Registro2[8*i +: 8];
            end
        end
        @(posedge i_clk);
        #1;
        check("misaligned", {31'b0, bus.o_Misaligned}, {31'b0, mis_m});
        check("debug_data", bus.o_DebugData, exp_dbg);
    endtask

    task automatic set_op(input logic we, input logic re, input logic [1:0] tf, input logic lu,
                          input logic [31:0] addr, input logic [31:0] data);
        bus.i_MemWrite     = we;
        bus.i_MemRead      = re;
        bus.i_TamanoFiltro = tf;
        bus.i_LoadUnsigned = lu;
        bus.i_ALU          = addr;
        bus.i_Registro2    = data;
    endtask

    function automatic vec_t mk(input logic we, input logic re, input logic [1:0] tf, input logic lu,
                                input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.re = re; v.tf = tf; v.lu = lu; v.addr = addr; v.data = data; v.exp = exp;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;

        i_reset = 1'b1;
        set_op(0, 0, 2'b11, 0, 32'h0, 32'h0);
        bus.i_Branch = 0; bus.i_Cero = 0; bus.i_PCBranch = 32'h0; bus.i_DebugAddr = 8'd4;
        do_cycle(rd);
        check("reset_mis", {31'b0, bus.o_Misaligned}, 32'h0);
        check("reset_dbg", bus.o_DebugData, 32'h0);
        i_reset = 1'b0;

        vecs.push_back(mk(0, 1, 2'b11, 0, 32'h0000_0000, 32'h0, 32'h0000_0000));
        vecs.push_back(mk(0, 1, 2'b11, 0, 32'h0000_03FC, 32'h0, 32'h0000_0000));
        vecs.push_back(mk(1, 0, 2'b11, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk(0, 1, 2'b11, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 0, 2'b11, 0, 32'h0000_0020, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 2'b00, 0, 32'h0000_0023, 32'h1234_5680, 32'h0));
        vecs.push_back(mk(1, 0, 2'b01, 0, 32'h0000_0020, 32'hABCD_F00D, 32'h0));
        vecs.push_back(mk(0, 1, 2'b11, 0, 32'h0000_0020, 32'h0, 32'h8000_F00D));
        vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0023, 32'h0, 32'hFFFF_FF80));
        vecs.push_back(mk(0, 1, 2'b00, 1, 32'h0000_0023, 32'h0, 32'h0000_0080));
        vecs.push_back(mk(0, 1, 2'b01, 0, 32'h0000_0020, 32'h0, 32'hFFFF_F00D));
        vecs.push_back(mk(0, 1, 2'b01, 1, 32'h0000_0020, 32'h0, 32'h0000_F00D));
        vecs.push_back(mk(0, 1, 2'b01, 0, 32'h0000_0022, 32'h0, 32'hFFFF_8000));
        vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0022, 32'h0, 32'h0000_0000));
        vecs.push_back(mk(0, 1, 2'b10, 0, 32'h0000_0020, 32'h0, 32'h8000_F00D));
        vecs.push_back(mk(1, 0, 2'b11, 0, 32'h0000_0404, 32'hAAAA_5555, 32'h0));
        vecs.push_back(mk(0, 1, 2'b11, 0, 32'h0000_0004, 32'h0, 32'hAAAA_5555));
        vecs.push_back(mk(0, 0, 2'b11, 0, 32'h0000_0010, 32'h0, 32'h0000_0000));

        foreach (vecs[k]) begin
            set_op(vecs[k].we, vecs[k].re, vecs[k].tf, vecs[k].lu, vecs[k].addr, vecs[k].data);
            do_cycle(rd);
            check($sformatf("vec%0d", k), rd, vecs[k].exp);
        end
        check("debug_word4", bus.o_DebugData, 32'hDEAD_BEEF);

        // Same-cycle load and store to one word.
        set_op(1, 1, 2'b11, 0, 32'h0000_0004, 32'h1111_1111);
        do_cycle(rd);
        check("conflict_old", rd, 32'hAAAA_5555);
        set_op(0, 1, 2'b11, 0, 32'h0000_0004, 32'h0);
        do_cycle(rd);
        check("conflict_new", rd, 32'h1111_1111);

        bus.i_Branch = 1; bus.i_Cero = 1; bus.i_PCBranch = 32'h0000_0040;
        set_op(0, 0, 2'b11, 0, 32'h0, 32'h0);
        do_cycle(rd);
        check("branch_taken", {31'b0, bus.o_PCSrc}, 32'h1);
        check("branch_target", bus.o_PCBranch, 32'h0000_0040);
        bus.i_Cero = 0;
        do_cycle(rd);
        check("branch_not_taken", {31'b0, bus.o_PCSrc}, 32'h0);
        bus.i_Branch = 0;

        bus.i_DebugAddr = 8'd12;
        set_op(1, 0, 2'b11, 0, 32'h0000_0031, 32'h1234_5678);
        do_cycle(rd);
        check("mis_set", {31'b0, bus.o_Misaligned}, 32'h1);
        set_op(0, 0, 2'b11, 0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) do_cycle(rd);
        check("mis_sticky", {31'b0, bus.o_Misaligned}, 32'h1);
        check("mis_store_suppressed", bus.o_DebugData, 32'h0);
        set_op(0, 1, 2'b01, 0, 32'h0000_0041, 32'h0);
        do_cycle(rd);
        check("mis_half_load", rd, 32'h0);
        i_reset = 1'b1;
        set_op(0, 0, 2'b11, 0, 32'h0, 32'h0);
        do_cycle(rd);
        i_reset = 1'b0;
        check("mis_cleared", {31'b0, bus.o_Misaligned}, 32'h0);

        bus.i_DebugAddr = 8'd20;
        set_op(1, 0, 2'b11, 0, 32'h0000_0050, 32'h5A5A_5A5A);
        do_cycle(rd);
        i_reset = 1'b1;
        do_cycle(rd);
        i_reset = 1'b0;
        set_op(0, 1, 2'b11, 0, 32'h0000_0050, 32'h0);
        do_cycle(rd);
        check("reset_beats_store", rd, 32'h0);

        for (int n = 0; n < 400; n++) begin
            addr = (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) addr = addr | ($urandom << 11);
            set_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), addr, $urandom);
            i_reset         = ($urandom_range(0, 59) == 0);
            bus.i_Branch    = 1'($urandom_range(0, 1));
            bus.i_Cero      = 1'($urandom_range(0, 1));
            bus.i_PCBranch  = $urandom;
            bus.i_DebugAddr = 8'($urandom_range(0, 15));
            do_cycle(rd);
        end
        i_reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/etapa_mem.md
Name: etapa_mem

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Contains the word-organised data memory and the store byte-lane merge logic, selected by TamanoFiltro.
- Also contains the load extract/extend logic, the branch-taken decision, a sticky misalignment flag and a registered debug read port.

Parameters:
- NBITS, 32, datapath and memory word width.
- MEM_WORDS, 256, data memory depth in words.
- ADDR_BITS, 8, word-index width; must equal log2(MEM_WORDS).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous active-high reset.
- i_ALU  in  NBITS  byte address from EX/MEM.
- i_Registro2  in  NBITS  store data from EX/MEM.
- i_MemWrite  in  1  store request.
- i_MemRead  in  1  load request.
- i_TamanoFiltro  in  2  access size: 00 byte, 01 halfword, 11 word, 10 reserved (treated as word).
- i_LoadUnsigned  in  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend.
- i_Branch  in  1  branch instruction in MEM.
- i_Cero  in  1  ALU zero flag.
- i_PCBranch  in  NBITS  branch target.
- i_DebugAddr  in  ADDR_BITS  debug word index.
- o_ReadData  out  NBITS  extracted/extended load data; combinational.
- o_PCSrc  out  1  branch taken; combinational.
- o_PCBranch  out  NBITS  passthrough of i_PCBranch.
- o_Misaligned  out  1  sticky misaligned-access flag.
- o_DebugData  out  NBITS  registered memory word at i_DebugAddr.

Behaviour:
- Synchronous reset (i_reset high at a rising edge): all MEM_WORDS words cleared to 0, o_Misaligned=0, o_DebugData=0. Reset wins over a simultaneous store.
- Address decode: word index = i_ALU[ADDR_BITS+1:2]. Byte offset = i_ALU[1:0]. Bits above ADDR_BITS+1 are ignored, so addresses wrap modulo 4*MEM_WORDS.
- Misaligned access:
  - halfword with i_ALU[0]=1, or word with i_ALU[1:0]!=00;
  - evaluated only when i_MemRead or i_MemWrite is high;
  - a misaligned store is suppressed (memory unchanged);
  - a misaligned load returns 0;
  - either case sets o_Misaligned on the next rising edge; it stays set until reset.
- Store on rising edge when i_MemWrite=1 and aligned. Byte lanes are little-endian, lane k = bits [8k+7:8k]:
  - byte: i_Registro2[7:0] written into lane offset; other lanes untouched;
  - halfword: i_Registro2[15:0] written into lanes offset, offset+1;
  - word: whole word written.
- Load is combinational (zero-latency) from the memory array, so MEM/WB can latch it in the same cycle:
  - byte: lane offset, extended per i_LoadUnsigned;
  - halfword: lanes offset+1:offset, extended per i_LoadUnsigned;
  - word: whole word.
- When i_MemRead=0, o_ReadData=0.
- Load and store to the same word in the same cycle: the load returns the old contents; the write takes effect after the edge.
- i_MemRead and i_MemWrite both high: the store is performed, and o_ReadData returns the pre-write word.
- o_PCSrc = i_Branch & i_Cero. o_PCBranch = i_PCBranch. No registering on either.
- Debug port:
  - o_DebugData is loaded each rising edge with mem[i_DebugAddr], giving 1-cycle latency;
  - it reflects the pre-store contents if a store to that word occurs on the same edge.
- Memory contents persist across cycles with no access. No other state exists.

Test Plan:
- Reset then read: assert i_reset 1 cycle, then load word at 0x0, 0x3FC -> o_ReadData=0, o_Misaligned=0, o_DebugData=0.
- Word store/load: store 0xDEADBEEF @0x10 (TF=11), then load word @0x10 -> 0xDEADBEEF; i_DebugAddr=4 -> o_DebugData=0xDEADBEEF one cycle later.
- Byte/half lanes: word 0 @0x20, store byte 0x80 @0x23, then store half 0xF00D @0x20:
  - word load @0x20 -> 0x8000F00D;
  - LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080;
  - LH @0x20 -> 0xFFFFF00D; LHU @0x20 -> 0x0000F00D.
- Misalignment: word store 0x12345678 @0x31 -> mem[12] unchanged, o_Misaligned=1 after the edge and still 1 ten cycles later; half load @0x41 -> o_ReadData=0; reset -> o_Misaligned=0.
- Wrap and same-cycle conflict: store word 0xAAAA5555 @0x404 -> read @0x004 returns 0xAAAA5555; read and store 0x11111111 to @0x004 in the same cycle -> o_ReadData=0xAAAA5555 that cycle, 0x11111111 next cycle.
- Branch and reset priority: i_Branch=1, i_Cero=1, i_PCBranch=0x00000040 -> o_PCSrc=1, o_PCBranch=0x40; i_Cero=0 -> o_PCSrc=0; store with i_reset=1 on the same edge -> memory reads 0.
